// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_unit_pkg : shared op indices, FSM states and helpers for muldiv_unit
// Revision 1.0
// ----------------------------------------------------------------------------
package muldiv_unit_pkg;

  localparam int OP_W     = 7;
  localparam int OP_MUL   = 0;
  localparam int OP_MULH  = 1;
  localparam int OP_MULHU = 2;
  localparam int OP_DIV   = 3;
  localparam int OP_MOD   = 4;
  localparam int OP_DIVU  = 5;
  localparam int OP_MODU  = 6;

  localparam logic [31:0] C_DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Keep only the lowest set bit so a malformed op vector still selects one op.
  function automatic logic [OP_W-1:0] op_lowest(input logic [OP_W-1:0] op);
    return op & (~op + {{(OP_W-1){1'b0}}, 1'b1});
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_div_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_unit_div_core : 32-bit unsigned restoring divider, one bit per step
// Revision 1.0
// ----------------------------------------------------------------------------
module muldiv_unit_div_core (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  logic [32:0] rem_q;
  logic [31:0] quot_q;
  logic [31:0] divisor_q;
  logic [33:0] w_shift;
  logic [33:0] w_diff;

  // The dividend shifts out of quot_q's MSB while quotient bits shift in at the LSB.
  assign w_shift = {rem_q, quot_q[31]};
  assign w_diff  = w_shift - {2'b00, divisor_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
    end else if (load_i) begin
      rem_q     <= '0;
      quot_q    <= dividend_i;
      divisor_q <= divisor_i;
    end else if (step_i) begin
      if (!w_diff[33]) begin
        rem_q  <= w_diff[32:0];
        quot_q <= {quot_q[30:0], 1'b1};
      end else begin
        rem_q  <= w_shift[32:0];
        quot_q <= {quot_q[30:0], 1'b0};
      end
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q[31:0];

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_unit : multi-cycle LoongArch mul/div unit with valid/ready handshakes
// Revision 1.0
// ----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [OP_W-1:0] op_i,
  input  logic [31:0]     src1_i,
  input  logic [31:0]     src2_i,
  input  logic            cancel_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [31:0]     result_o,
  output logic            busy_o
);

  state_e          state_q, state_d;
  logic            req_ready_q, resp_valid_q, busy_q;
  logic [31:0]     result_q;
  logic [5:0]      cnt_q;
  logic [OP_W-1:0] op_q;
  logic [31:0]     src1_q, src2_q;
  logic            div0_q;

  logic [OP_W-1:0] w_op_sel;
  logic            w_accept, w_is_mul, w_sgn_in, w_sgn_q;
  logic [31:0]     w_div_a, w_div_b, w_quot, w_rem;
  logic [31:0]     w_quot_fix, w_rem_fix, w_result;
  logic signed [32:0] w_a, w_b;
  logic signed [63:0] w_prod;
  logic [63:0]     w_mul_tap;

  assign w_op_sel = op_lowest(op_i);
  assign w_is_mul = |w_op_sel[OP_MULHU:OP_MUL];
  assign w_sgn_in = w_op_sel[OP_DIV] | w_op_sel[OP_MOD];
  assign w_accept = req_ready_q & req_valid_i & (|op_i) & ~cancel_i;

  // Low 64 bits of the 66-bit signed product are all any op consumes.
  assign w_a    = {op_q[OP_MULHU] ? 1'b0 : src1_q[31], src1_q};
  assign w_b    = {op_q[OP_MULHU] ? 1'b0 : src2_q[31], src2_q};
  assign w_prod = 64'(w_a) * 64'(w_b);

  generate
    if (MUL_LAT == 1) begin : g_mul_lat1
      assign w_mul_tap = w_prod;
    end else begin : g_mul_pipe
      logic [63:0] pipe_q [MUL_LAT-1];
      always_ff @(posedge clk_i) begin
        pipe_q[0] <= w_prod;
        for (int i = 1; i < MUL_LAT - 1; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign w_mul_tap = pipe_q[MUL_LAT-2];
    end
  endgenerate

  assign w_div_a = w_sgn_in ? abs32(src1_i) : src1_i;
  assign w_div_b = w_sgn_in ? abs32(src2_i) : src2_i;

  muldiv_unit_div_core u_div_core (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (w_accept & ~w_is_mul),
    .step_i     ((state_q == S_DIV) && (cnt_q != 6'd0)),
    .dividend_i (w_div_a),
    .divisor_i  (w_div_b),
    .quot_o     (w_quot),
    .rem_o      (w_rem)
  );

  assign w_sgn_q    = op_q[OP_DIV] | op_q[OP_MOD];
  assign w_quot_fix = div0_q ? C_DIV0_QUOT :
                      (w_sgn_q && (src1_q[31] ^ src2_q[31])) ? -w_quot : w_quot;
  assign w_rem_fix  = div0_q ? src1_q :
                      (w_sgn_q && src1_q[31]) ? -w_rem : w_rem;

  always_comb begin
    w_result = '0;
    case (op_q)
      7'b0000001:             w_result = w_mul_tap[31:0];
      7'b0000010, 7'b0000100: w_result = w_mul_tap[63:32];
      7'b0001000, 7'b0100000: w_result = w_quot_fix;
      7'b0010000, 7'b1000000: w_result = w_rem_fix;
      default:                w_result = '0;
    endcase
  end

  // Divide-by-zero enters DIV with cnt 0 so the fix-up edge produces its result.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (w_accept) state_d = w_is_mul ? S_MUL : S_DIV;
      S_MUL:   if (cnt_q == 6'd1) state_d = S_DONE;
      S_DIV:   if (cnt_q == 6'd0) state_d = S_DONE;
      S_DONE:  if (resp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (cancel_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      result_q     <= '0;
      cnt_q        <= '0;
      op_q         <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      div0_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= (state_d == S_IDLE);
      resp_valid_q <= (state_d == S_DONE);
      busy_q       <= (state_d != S_IDLE);
      if (w_accept) begin
        op_q   <= w_op_sel;
        src1_q <= src1_i;
        src2_q <= src2_i;
        div0_q <= (src2_i == 32'd0);
        if (w_is_mul)              cnt_q <= 6'(MUL_LAT);
        else if (src2_i == 32'd0)  cnt_q <= 6'd0;
        else                       cnt_q <= 6'd32;
      end else if ((state_q == S_MUL) || ((state_q == S_DIV) && (cnt_q != 6'd0))) begin
        cnt_q <= cnt_q - 6'd1;
      end
      if ((state_q != S_DONE) && (state_d == S_DONE)) begin
        result_q <= w_result;
      end
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign busy_o       = busy_q;
  assign result_o     = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_muldiv_unit : table, random and corner-sequence bench for muldiv_unit
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int C_MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, cancel, resp_valid, resp_ready, busy;
  logic [6:0]  op;
  logic [31:0] src1, src2, result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.MUL_LAT(C_MUL_LAT)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .op_i         (op),
    .src1_i       (src1),
    .src2_i       (src2),
    .cancel_i     (cancel),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .result_o     (result),
    .busy_o       (busy)
  );

  typedef struct {
    logic [6:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference: signed/unsigned arithmetic on 64-bit integers, lowest op bit wins.
  function automatic logic [31:0] ref_result(input logic [6:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (o[0])      begin t = sa * sb; return t[31:0];  end
    else if (o[1]) begin t = sa * sb; return t[63:32]; end
    else if (o[2]) begin t = ua * ub; return t[63:32]; end
    else if (o[3]) begin if (b == 0) return 32'hFFFF_FFFF; t = sa / sb; return t[31:0]; end
    else if (o[4]) begin if (b == 0) return a;             t = sa % sb; return t[31:0]; end
    else if (o[5]) begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
    else if (o[6]) begin if (b == 0) return a;             return a % b; end
    return 32'd0;
  endfunction

  function automatic int ref_latency(input logic [6:0] o, input logic [31:0] b);
    if (|o[2:0]) return C_MUL_LAT;
    return (b == 0) ? 1 : 33;
  endfunction

  task automatic run_op(input logic [6:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    chk("ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; op = o; src1 = a; src2 = b;
    @(negedge clk);
    req_valid = 1'b0; op = '0;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = result;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("ready_after_handshake", {31'd0, req_ready}, 32'd1);
  endtask

  logic [31:0] r, r0;
  int          lat, seen, n;
  logic [6:0]  rop;
  logic [31:0] ra, rb;

  initial begin
    vecs[0]  = '{7'b0000001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 2};
    vecs[1]  = '{7'b0000010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 2};
    vecs[2]  = '{7'b0000100, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 2};
    vecs[3]  = '{7'b0001000, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33};
    vecs[4]  = '{7'b0010000, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33};
    vecs[5]  = '{7'b0100000, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33};
    vecs[6]  = '{7'b1000000, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 33};
    vecs[7]  = '{7'b0100000, 32'd5,        32'd0, 32'hFFFF_FFFF, 1};
    vecs[8]  = '{7'b1000000, 32'd5,        32'd0, 32'h0000_0005, 1};
    vecs[9]  = '{7'b0001000, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1};
    vecs[10] = '{7'b0001000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
    vecs[11] = '{7'b0010000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};
    vecs[12] = '{7'b1010000, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33};
    vecs[13] = '{7'b0000110, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 2};

    rst = 1'b1; req_valid = 1'b0; op = '0; src1 = '0; src2 = '0;
    cancel = 1'b0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_result", result, 32'd0);

    // op == 0 must be ignored
    req_valid = 1'b1; op = '0;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    chk("zero_op_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat);
      chk($sformatf("vec%0d_result", i), r, vecs[i].exp_res);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
    end

    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 9);
      rop = (n < 7) ? 7'(1 << n) : 7'($urandom_range(1, 127));
      case ($urandom_range(0, 3))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        2: ra = $urandom_range(0, 50);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 9);
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, r, lat);
      chk($sformatf("rand%0d_result op=%b a=%h b=%h", i, rop, ra, rb), r, ref_result(rop, ra, rb));
      chk($sformatf("rand%0d_latency", i), lat, ref_latency(rop, rb));
    end

    // Back-pressure with a competing request held during DONE
    @(negedge clk);
    req_valid = 1'b1; op = 7'b0000001; src1 = 32'hFFFF_FFFF; src2 = 32'd2;
    @(negedge clk);
    op = 7'b0100000; src1 = 32'd9; src2 = 32'd3;
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    r0 = result;
    chk("bp_first_result", r0, 32'hFFFF_FFFE);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_result_stable", result, r0);
      chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_busy", {31'd0, busy}, 32'd1);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_release_valid", {31'd0, resp_valid}, 32'd0);
    chk("bp_no_same_cycle_accept", {31'd0, busy}, 32'd0);
    req_valid = 1'b0; op = '0;

    // Cancel at E10 of a divide
    @(negedge clk);
    req_valid = 1'b1; op = 7'b0001000; src1 = 32'd100; src2 = 32'd7;
    @(negedge clk);
    req_valid = 1'b0; op = '0; seen = 0;
    repeat (9) begin @(negedge clk); if (resp_valid) seen = 1; end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_idle_busy", {31'd0, busy}, 32'd0);
    chk("cancel_idle_ready", {31'd0, req_ready}, 32'd1);
    repeat (40) begin @(negedge clk); if (resp_valid) seen = 1; end
    chk("cancel_no_resp", seen, 0);
    run_op(7'b0000100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
    chk("post_cancel_mulhu", r, 32'hFFFF_FFFE);
    chk("post_cancel_latency", lat, C_MUL_LAT);

    // Same interruption with reset
    @(negedge clk);
    req_valid = 1'b1; op = 7'b0001000; src1 = 32'd100; src2 = 32'd7;
    @(negedge clk);
    req_valid = 1'b0; op = '0; seen = 0;
    repeat (9) begin @(negedge clk); if (resp_valid) seen = 1; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_result", result, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    repeat (40) begin @(negedge clk); if (resp_valid) seen = 1; end
    chk("rst_no_resp", seen, 0);

    // Cancel while holding a result in DONE
    @(negedge clk);
    req_valid = 1'b1; op = 7'b0000001; src1 = 32'd6; src2 = 32'd7;
    @(negedge clk);
    req_valid = 1'b0; op = '0; n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("done_cancel_pre_result", result, 32'd42);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("done_cancel_valid", {31'd0, resp_valid}, 32'd0);
    chk("done_cancel_ready", {31'd0, req_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle integer multiply/divide unit with its own sequencing controller. It executes the seven LoongArch M-extension ops decoded in ID: mul.w, mulh.w, mulh.wu, div.w, mod.w, div.wu, mod.wu. It sits beside the ALU in EX. A valid/ready handshake on each side lets EX stall while an operation is in flight and lets MEM back-pressure the result.

## Interface
- MUL_LAT, default 2: edges from acceptance to mul-type result valid; legal range 1..4.
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  EX presents an operation
- req_ready  out  1  unit can accept; high only in IDLE
- op  in  7  one-hot {modu, divu, mod, div, mulhu, mulh, mul}; bit 0 = mul
- src1  in  32  rj value (dividend / multiplicand)
- src2  in  32  rk value (divisor / multiplier)
- cancel  in  1  flush; kills any in-flight op
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- result  out  32  op result
- busy  out  1  state != IDLE

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - Accept when req_valid & req_ready & (op != 0) & ~cancel.
  - On accept, latch op, src1 and src2.
  - Mul-type ops go to MUL with cnt = MUL_LAT.
  - Div-type ops with src2 == 0 go straight to DONE with quotient = 32'hFFFFFFFF and remainder = src1, for both signed and unsigned.
  - Other div-type ops go to DIV with cnt = 32.
  - op == 0 with req_valid is ignored; no state change.
  - If op is not one-hot, the lowest set bit wins.
- MUL:
  - Operands are extended to 33 bits: sign-extended for mul and mulh, zero-extended for mulhu.
  - The product is the 66-bit signed product, pipelined MUL_LAT deep.
  - Result: mul takes [31:0]; mulh and mulhu take [63:32].
  - cnt decrements each edge; at cnt == 1, register the result and go to DONE.
- DIV:
  - Signed ops divide |src1| by |src2| (unsigned magnitudes); unsigned ops use raw operands.
  - One restoring step per edge in div_core: remainder shift-subtract, quotient bit shifted in.
  - After 32 steps, apply sign fix-up on the next edge, then go to DONE.
  - Signed quotient is negated iff src1[31] ^ src2[31]. Signed remainder takes the sign of src1.
  - Overflow 0x80000000 / 0xFFFFFFFF wraps naturally: quotient 0x80000000, remainder 0.
  - div/divu output the quotient; mod/modu output the remainder.
- DONE:
  - resp_valid = 1; result holds stable.
  - On resp_ready, go to IDLE.
  - No new request is accepted in the same cycle.
- cancel, in any state: the next edge goes to IDLE, resp_valid drops, and the result is discarded. cancel together with req_valid in IDLE means nothing is accepted.
- rst has the same effect as cancel plus clearing result to 0.

## Timing
- Reset values:
  - state IDLE
  - req_ready 1
  - resp_valid 0
  - busy 0
  - result 32'h0
- Latency, counted from acceptance edge E0:
  - Mul-type: resp_valid high after edge E(MUL_LAT).
  - Div-type: 32 iterations on E1..E32, fix-up on E33; resp_valid high after E33.
  - Divide-by-zero: resp_valid high after E1.
- Occupancy: minimum gap between two accepts is latency + 1 cycle (the DONE handshake cycle, then the IDLE accept).
- req_ready, resp_valid and busy are decoded from registered state only. There is no combinational path from req_valid, resp_ready or cancel to any output.
- result changes only on the edge that enters DONE or on reset.
- Back-pressure: resp_valid and result stay constant while resp_ready = 0, indefinitely.

## Structure
- Shared header muldiv_defs.vh holds:
  - op bit indices (OP_MUL=0 .. OP_MODU=6)
  - state encodings
  - the divide-by-zero quotient constant
  ID and EX include it so the op vector packing matches.
- Sub-module div_core: 32-bit unsigned restoring divider. It has load/step inputs, holds the 33-bit partial remainder and 32-bit quotient, and does not know about signs.
- Sign handling, the mul pipeline, the FSM and cnt live in muldiv_unit.

## Test plan
- mul -1×2: src1=0xFFFFFFFF, src2=2 with op mul, then mulh, then mulhu -> results 0xFFFFFFFE, 0xFFFFFFFF, 0x00000001. resp_valid rises after edge 2 with MUL_LAT=2.
- Division signs: src1=0xFFFFFFF9 (-7), src2=2 with div, mod, divu, modu -> 0xFFFFFFFD, 0xFFFFFFFF, 0x7FFFFFFC, 0x00000001. resp_valid rises after edge 33 each time.
- Divide by zero: divu 5/0 -> 0xFFFFFFFF; modu 5/0 -> 0x00000005; div -5/0 -> 0xFFFFFFFF. resp_valid rises after edge 1.
- Overflow: div 0x80000000 / 0xFFFFFFFF -> 0x80000000; mod -> 0x00000000.
- Back-pressure: hold resp_ready=0 for 10 cycles after resp_valid -> result constant, req_ready=0, busy=1. Raise resp_ready -> IDLE next edge and req_ready=1.
- Cancel/reset mid-op:
  - Assert cancel at E10 of a div -> IDLE after E11, with no resp_valid ever seen.
  - Then issue mulhu 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - Repeat the same interruption with rst -> result = 0.
